// File: rtl/ga_pkg.sv
// Shared definitions for the Cartesian GA core: controller phase codes,
// evaluation-engine state codes and the fitness width derived from the
// primary input count.
package ga_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'b000,
    PH_FITNESS = 3'b001,
    PH_SELECT  = 3'b010,
    PH_MUTATE  = 3'b011,
    PH_INIT    = 3'b100,
    PH_DONE    = 3'b111
  } phase_e;

  // Evaluation engine states the controller reacts to.
  localparam logic [2:0] EVAL_FOUND    = 3'b101;
  localparam logic [2:0] EVAL_FINISHED = 3'b110;

  // Fitness counts mismatching truth-table rows, so it needs two bits of headroom.
  function automatic int fitnessWidth(input int primaryInputCount);
    return primaryInputCount + 32'sd2;
  endfunction

endpackage

// File: rtl/ga_elite_tracker.sv
// Best-gene tracker: watches the evaluation engine's gene counter and keeps
// the lowest fitness seen since the last reload together with its gene index.
// Ties keep the earlier index. A counter decrease (engine re-armed) only
// resynchronises the stored counter copy.
module ga_elite_tracker #(
  parameter int fitWidth = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trackEn,
  input  logic                reload,
  input  logic [7:0]          fitCounter,
  input  logic [fitWidth-1:0] fitness,
  output logic [fitWidth-1:0] bestFitness,
  output logic [7:0]          bestIndex
);

  logic [7:0]          prevCount;
  logic                newGene;
  logic [fitWidth-1:0] bestNext;
  logic [7:0]          indexNext;

  // Decide whether a freshly evaluated gene beats the current best.
  always_comb begin
    newGene   = (fitCounter > prevCount);
    bestNext  = bestFitness;
    indexNext = bestIndex;
    if (reload) begin
      bestNext  = '1;
      indexNext = 8'd0;
    end else if (trackEn && newGene && (fitness < bestFitness)) begin
      bestNext  = fitness;
      indexNext = fitCounter - 8'd1;
    end else begin
      bestNext  = bestFitness;
      indexNext = bestIndex;
    end
  end

  // Hold the counter copy and the best-gene record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prevCount   <= 8'd0;
      bestFitness <= '1;
      bestIndex   <= 8'd0;
    end else begin
      prevCount   <= fitCounter;
      bestFitness <= bestNext;
      bestIndex   <= indexNext;
    end
  end

endmodule

// File: rtl/ga_phase_controller.sv
// Top-level GA sequencer. Drives the phase code shared by the initialiser,
// evaluation, selection and mutation blocks, counts generations and stops on
// a perfect gene or when the generation budget is used up.
// Optional feature macro: GA_ELITE_TRACK_EN enables per-generation best-gene
// tracking; without it bestFitness/bestIndex are tied to all ones / zero.
module ga_phase_controller import ga_pkg::*; #(
  parameter int population        = 24,
  parameter int maxGeneration     = 1000,
  parameter int geneResultBit     = 2,
  parameter int primaryInputCount = 8,
  parameter int genBit            = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       initDone,
  input  logic                                       selectDone,
  input  logic                                       mutateDone,
  input  logic [2:0]                                 state_evaluationFSM,
  input  logic [7:0]                                 fitCounter,
  input  logic [fitnessWidth(primaryInputCount)-1:0] fitness,
  output logic [2:0]                                 state_controller,
  output logic [genBit-1:0]                          generation,
  output logic [fitnessWidth(primaryInputCount)-1:0] bestFitness,
  output logic [7:0]                                 bestIndex,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       found
);

  localparam int                FW        = fitnessWidth(primaryInputCount);
  localparam logic [genBit-1:0] GEN_LIMIT = genBit'(maxGeneration);
  localparam logic [genBit-1:0] GEN_ONE   = genBit'(1);

  phase_e            phase;
  phase_e            phaseNext;
  logic [genBit-1:0] genNext;
  logic              doneNext;
  logic              foundNext;
  logic              busyNext;
  logic              reloadTracker;

  // Population size and perfect-fitness value are fixed by the neighbouring blocks.
  logic unusedParams;
  assign unusedParams = ^{32'(population), 32'(geneResultBit)};

  assign state_controller = phase;

  // Next phase, generation count and run flags.
  always_comb begin
    phaseNext     = phase;
    genNext       = generation;
    doneNext      = done;
    foundNext     = found;
    reloadTracker = 1'b0;
    case (phase)
      PH_IDLE: begin
        if (start) begin
          phaseNext     = PH_INIT;
          genNext       = '0;
          doneNext      = 1'b0;
          foundNext     = 1'b0;
          reloadTracker = 1'b1;
        end else begin
          phaseNext = PH_IDLE;
        end
      end
      PH_INIT: begin
        if (initDone) begin
          phaseNext = PH_FITNESS;
        end else begin
          phaseNext = PH_INIT;
        end
      end
      PH_FITNESS: begin
        if (state_evaluationFSM == EVAL_FOUND) begin
          phaseNext = PH_DONE;
          doneNext  = 1'b1;
          foundNext = 1'b1;
        end else if (state_evaluationFSM == EVAL_FINISHED) begin
          phaseNext = PH_SELECT;
        end else begin
          phaseNext = PH_FITNESS;
        end
      end
      PH_SELECT: begin
        if (selectDone) begin
          phaseNext = PH_MUTATE;
        end else begin
          phaseNext = PH_SELECT;
        end
      end
      PH_MUTATE: begin
        if (mutateDone) begin
          reloadTracker = 1'b1;
          // Saturate rather than wrap once the budget is reached.
          if (generation < GEN_LIMIT) begin
            genNext = generation + GEN_ONE;
          end else begin
            genNext = generation;
          end
          if (genNext == GEN_LIMIT) begin
            phaseNext = PH_DONE;
            doneNext  = 1'b1;
            foundNext = 1'b0;
          end else begin
            phaseNext = PH_FITNESS;
          end
        end else begin
          phaseNext = PH_MUTATE;
        end
      end
      PH_DONE: begin
        doneNext = 1'b1;
        if (!start) begin
          phaseNext = PH_IDLE;
        end else begin
          phaseNext = PH_DONE;
        end
      end
      default: begin
        phaseNext = PH_IDLE;
      end
    endcase
    busyNext = (phaseNext != PH_IDLE) && (phaseNext != PH_DONE);
  end

  // Phase, generation and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= PH_IDLE;
      generation <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
    end else begin
      phase      <= phaseNext;
      generation <= genNext;
      busy       <= busyNext;
      done       <= doneNext;
      found      <= foundNext;
    end
  end

`ifdef GA_ELITE_TRACK_EN
  ga_elite_tracker #(
    .fitWidth(FW)
  ) eliteTracker (
    .clk        (clk),
    .reset      (reset),
    .trackEn    (phase == PH_FITNESS),
    .reload     (reloadTracker),
    .fitCounter (fitCounter),
    .fitness    (fitness),
    .bestFitness(bestFitness),
    .bestIndex  (bestIndex)
  );
`else
  logic unusedTrackInputs;
  assign unusedTrackInputs = ^{fitCounter, fitness, reloadTracker};
  assign bestFitness       = {FW{1'b1}};
  assign bestIndex         = 8'd0;
`endif

endmodule
